// File: rtl/define_state.sv
// Shared fetch-FSM states and RGB packing constants for the SRAM pixel reader.
package define_state;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam int GROUP_WORDS = 3;
  localparam int ADDR_W      = 18;
  localparam int PIX_W       = 24;
endpackage

// File: rtl/pixel_fifo.sv
// Show-ahead pixel FIFO: pop_data is the head entry whenever empty=0.
import define_state::*;

module pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = PIX_W
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Credit accounting upstream makes this unreachable.
  a_no_overflow: assert property (@(posedge clock) disable iff (!resetn)
    !(push && full && !pop));
endmodule

// File: rtl/rgb_sram_reader.sv
// Streams a frame of packed RGB (3 words -> 2 pixels) from SRAM into a
// credit-controlled pixel FIFO with a valid/ready output.
import define_state::*;

module rgb_sram_reader #(
  parameter int TOTAL_PIXELS = 76800,
  parameter int FIFO_DEPTH   = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  input  logic [17:0] Base_address,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic [7:0]  Pixel_R,
  output logic [7:0]  Pixel_G,
  output logic [7:0]  Pixel_B,
  output logic        Pixel_valid,
  input  logic        Pixel_ready,
  output logic        Busy,
  output logic        Done
);
  localparam int          CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int          OCC_W    = CNT_W + 1;
  localparam int          RL       = READ_LATENCY;
  localparam logic [16:0] LAST_PIX = 17'(TOTAL_PIXELS);
  localparam logic [1:0]  LAST_IDX = 2'(GROUP_WORDS - 1);

  state_t                 state, nxt;
  logic [17:0]            addr_cnt;
  logic [16:0]            pix_cnt;
  logic [1:0]             issue_idx;
  logic [OCC_W-1:0]       reserved, occ;
  logic [RL:0]            vld_pipe;
  logic [RL:0][1:0]       idx_pipe;
  logic [15:0]            w0_q;
  logic [7:0]             r1_q;
  logic                   issue, grp_start, start_ok, drained;
  logic                   push, pop, fifo_empty;
  logic [PIX_W-1:0]       push_data, pop_data;
  logic [CNT_W-1:0]       fifo_count;
  logic [1:0]             cap_idx;

  // Pixels already in the FIFO plus pixels owed by in-flight groups.
  assign occ      = OCC_W'(fifo_count) + reserved + OCC_W'(2);
  assign start_ok = (occ <= OCC_W'(FIFO_DEPTH));
  assign drained  = (vld_pipe == '0) && (reserved == '0);

  always_comb begin
    nxt       = state;
    issue     = 1'b0;
    grp_start = 1'b0;
    case (state)
      S_IDLE:  if (Start) nxt = S_FETCH;
      S_FETCH: begin
        if (issue_idx != 2'd0) issue = 1'b1;
        else if (start_ok) begin
          issue     = 1'b1;
          grp_start = 1'b1;
        end
        if (issue && issue_idx == LAST_IDX && pix_cnt == LAST_PIX) nxt = S_DRAIN;
      end
      S_DRAIN: if (drained) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state        <= S_IDLE;
      SRAM_address <= '0;
      addr_cnt     <= '0;
      pix_cnt      <= '0;
      issue_idx    <= '0;
      reserved     <= '0;
      vld_pipe     <= '0;
      idx_pipe     <= '0;
      w0_q         <= '0;
      r1_q         <= '0;
      Done         <= 1'b0;
    end else begin
      state <= nxt;
      Done  <= (state == S_DRAIN) && (nxt == S_IDLE);
      if (state == S_IDLE && Start) begin
        addr_cnt  <= Base_address;
        pix_cnt   <= '0;
        issue_idx <= '0;
      end
      if (issue) begin
        SRAM_address <= addr_cnt;
        addr_cnt     <= addr_cnt + 18'd1;
        issue_idx    <= (issue_idx == LAST_IDX) ? 2'd0 : issue_idx + 2'd1;
      end
      if (grp_start) pix_cnt <= pix_cnt + 17'd2;
      reserved <= reserved + OCC_W'({grp_start, 1'b0}) - OCC_W'(push);
      vld_pipe <= {vld_pipe[RL-1:0], issue};
      idx_pipe <= {idx_pipe[RL-1:0], issue_idx};
      if (vld_pipe[RL]) begin
        if (cap_idx == 2'd0) w0_q <= SRAM_read_data;
        if (cap_idx == 2'd1) r1_q <= SRAM_read_data[7:0];
      end
    end
  end

  // w1 completes pixel 0 and leaves R1; w2 completes pixel 1.
  assign cap_idx   = idx_pipe[RL];
  assign push      = vld_pipe[RL] && (cap_idx != 2'd0);
  assign push_data = (cap_idx == 2'd1) ? {w0_q, SRAM_read_data[15:8]}
                                       : {r1_q, SRAM_read_data};

  pixel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PIX_W)) u_fifo (
    .clock     (Clock),
    .resetn    (Resetn),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign Pixel_valid = !fifo_empty;
  assign pop         = Pixel_valid && Pixel_ready;
  assign Pixel_R     = pop_data[23:16];
  assign Pixel_G     = pop_data[15:8];
  assign Pixel_B     = pop_data[7:0];
  assign Busy        = (state != S_IDLE);
  assign SRAM_we_n   = 1'b1;
endmodule

// File: tb/tb_rgb_sram_reader.sv
// Scoreboard bench: frames are queued at Start, a negedge monitor checks
// pixels on each handshake and the SRAM address sequence.
module tb_rgb_sram_reader;
  localparam int          NPIX  = 16;
  localparam int          NWORD = NPIX * 3 / 2;
  localparam int          RL    = 2;
  localparam logic [17:0] BASE  = 18'd146944;
  localparam logic [15:0] WORDS [NWORD] = '{
    16'h1122, 16'h3344, 16'h5566, 16'h7788, 16'h99AA, 16'hBBCC,
    16'hDEAD, 16'hBEEF, 16'h0102, 16'h0304, 16'h0506, 16'h0708,
    16'hF0E1, 16'hD2C3, 16'hB4A5, 16'h9687, 16'h7869, 16'h5A4B,
    16'h0F1E, 16'h2D3C, 16'h4B5A, 16'h6978, 16'h8796, 16'hA5B4};

  logic        clock_50 = 1'b0;
  logic        Resetn, Start, SRAM_we_n, Pixel_valid, Pixel_ready, Busy, Done;
  logic [17:0] Base_address, SRAM_address;
  logic [15:0] SRAM_read_data, sp0, sp1;
  logic [7:0]  Pixel_R, Pixel_G, Pixel_B;

  int          errors = 0, checks = 0;
  logic [23:0] exp_q [$];
  int          rd_cnt = 0;
  int          rdy_mode = 0;
  logic        rdy_fix = 1'b1;

  always #5 clock_50 = ~clock_50;

  rgb_sram_reader #(.TOTAL_PIXELS(NPIX), .FIFO_DEPTH(8), .READ_LATENCY(RL)) dut (
    .Clock(clock_50), .Resetn(Resetn), .Start(Start), .Base_address(Base_address),
    .SRAM_address(SRAM_address), .SRAM_we_n(SRAM_we_n), .SRAM_read_data(SRAM_read_data),
    .Pixel_R(Pixel_R), .Pixel_G(Pixel_G), .Pixel_B(Pixel_B),
    .Pixel_valid(Pixel_valid), .Pixel_ready(Pixel_ready), .Busy(Busy), .Done(Done));

  function automatic logic [15:0] sram_word(input logic [17:0] a);
    int off;
    off = int'(a) - int'(BASE);
    if (off >= 0 && off < NWORD) return WORDS[off];
    return 16'hFFFF;
  endfunction

  // Two-cycle read latency SRAM model.
  always @(posedge clock_50) begin
    sp0 <= sram_word(SRAM_address);
    sp1 <= sp0;
  end
  assign SRAM_read_data = sp1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Pixel_ready driver: 0 fixed, 1 random, 2 toggling.
  initial begin
    Pixel_ready = 1'b1;
    forever begin
      @(posedge clock_50); #1;
      case (rdy_mode)
        1:       Pixel_ready = 1'($urandom_range(0, 1));
        2:       Pixel_ready = ~Pixel_ready;
        default: Pixel_ready = rdy_fix;
      endcase
    end
  end

  // Monitor: pixel scoreboard, hold stability and read address order.
  initial begin
    logic [17:0] last_addr, rd_base;
    logic        addr_on, hold;
    logic [23:0] hold_pix, pix, e;
    last_addr = '0; rd_base = '0; addr_on = 1'b0; hold = 1'b0; hold_pix = '0;
    forever begin
      @(negedge clock_50);
      pix = {Pixel_R, Pixel_G, Pixel_B};
      if (!Resetn) begin
        exp_q.delete();
        addr_on = 1'b0;
        hold    = 1'b0;
      end else begin
        if (hold && Pixel_valid) chk("hold_stable", 32'(pix), 32'(hold_pix));
        if (Pixel_valid && Pixel_ready) begin
          if (exp_q.size() == 0) chk("unexpected_pixel", 32'(pix), 32'hDEADDEAD);
          else begin
            e = exp_q.pop_front();
            chk("pixel", 32'(pix), 32'(e));
          end
        end
        hold     = Pixel_valid && !Pixel_ready;
        hold_pix = pix;
        if (Start && !Busy) begin
          addr_on = 1'b1;
          rd_base = Base_address;
          rd_cnt  = 0;
        end else if (addr_on && SRAM_address != last_addr) begin
          chk("read_addr", 32'(SRAM_address), 32'(rd_base + 18'(rd_cnt)));
          rd_cnt++;
        end
      end
      last_addr = SRAM_address;
    end
  end

  task automatic start_frame(input bit hand);
    logic [15:0] w0, w1, w2;
    int g0;
    @(posedge clock_50); #1;
    Start = 1'b1; Base_address = BASE;
    g0 = 0;
    if (hand) begin
      exp_q.push_back(24'h112233); exp_q.push_back(24'h445566);
      exp_q.push_back(24'h778899); exp_q.push_back(24'hAABBCC);
      g0 = 2;
    end
    for (int g = g0; g < NPIX / 2; g++) begin
      w0 = WORDS[3*g]; w1 = WORDS[3*g+1]; w2 = WORDS[3*g+2];
      exp_q.push_back({w0, w1[15:8]});
      exp_q.push_back({w1[7:0], w2});
    end
    @(posedge clock_50); #1;
    Start = 1'b0;
  endtask

  task automatic end_frame(input string nm);
    int n;
    n = 0;
    while (!Done && n < 3000) begin @(negedge clock_50); n++; end
    chk({nm, "_done"}, 32'(Done), 32'd1);
    chk({nm, "_reads"}, 32'(rd_cnt), 32'(NWORD));
    chk({nm, "_last_addr"}, 32'(SRAM_address), 32'(BASE + 18'(NWORD - 1)));
    @(negedge clock_50);
    chk({nm, "_done_pulse"}, 32'(Done), 32'd0);
    chk({nm, "_idle"}, 32'(Busy), 32'd0);
    n = 0;
    while (Pixel_valid && n < 3000) begin @(negedge clock_50); n++; end
    chk({nm, "_drained"}, 32'(Pixel_valid), 32'd0);
    chk({nm, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    Resetn = 1'b0; Start = 1'b0; Base_address = '0;
    repeat (3) @(posedge clock_50);
    #1 Resetn = 1'b1;
    @(negedge clock_50);
    chk("rst_valid", 32'(Pixel_valid), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_addr", 32'(SRAM_address), 32'd0);
    chk("we_n", 32'(SRAM_we_n), 32'd1);

    // Basic frame, always ready.
    rdy_mode = 0; rdy_fix = 1'b1;
    start_frame(1'b1);
    @(negedge clock_50);
    chk("basic_busy", 32'(Busy), 32'd1);
    end_frame("basic");

    // Consumer stalled: fetch stops at 8 pixels (4 groups, 12 words).
    rdy_fix = 1'b0;
    start_frame(1'b0);
    repeat (100) @(negedge clock_50);
    chk("stall_busy", 32'(Busy), 32'd1);
    chk("stall_reads", 32'(rd_cnt), 32'd12);
    chk("stall_addr", 32'(SRAM_address), 32'(BASE + 18'd11));
    chk("stall_valid", 32'(Pixel_valid), 32'd1);
    chk("stall_head", 32'({Pixel_R, Pixel_G, Pixel_B}), 32'h112233);
    rdy_fix = 1'b1;
    end_frame("stall");

    // Random backpressure.
    rdy_mode = 1;
    start_frame(1'b0);
    end_frame("random");

    // Second Start while busy must be ignored.
    rdy_mode = 0;
    start_frame(1'b0);
    repeat (4) @(posedge clock_50);
    #1 Start = 1'b1; Base_address = BASE + 18'd100;
    @(posedge clock_50); #1 Start = 1'b0;
    end_frame("restart_ignored");

    // One-cycle reset in the middle of fetching, then refetch.
    start_frame(1'b0);
    repeat (6) @(posedge clock_50);
    #1 Resetn = 1'b0;
    @(posedge clock_50); #1 Resetn = 1'b1;
    @(negedge clock_50);
    chk("midrst_valid", 32'(Pixel_valid), 32'd0);
    chk("midrst_busy", 32'(Busy), 32'd0);
    chk("midrst_done", 32'(Done), 32'd0);
    chk("midrst_addr", 32'(SRAM_address), 32'd0);
    start_frame(1'b0);
    end_frame("after_reset");

    // Ready toggling every cycle.
    rdy_mode = 2;
    start_frame(1'b0);
    end_frame("toggle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
